// File: rtl/trace_pkg.sv
// trace_pkg: shared entry layout and helpers for the CPU trace monitor.
package trace_pkg;
  localparam int PC_LSB = 0;
  function automatic int stall_bit(int pc_w);
    return pc_w;
  endfunction
  function automatic int flush_bit(int pc_w);
    return pc_w + 1;
  endfunction
  function automatic int entry_w(int pc_w);
    return pc_w + 2;
  endfunction
  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(logic [63:0] v, int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor_if: valid/ready trace readout port.
interface cpu_trace_monitor_if #(parameter int W = 34);
  logic rd_valid_o;
  logic rd_ready_i;
  logic [W-1:0] rd_data_o;
  modport slave(output rd_valid_o, rd_data_o, input rd_ready_i);
  modport master(input rd_valid_o, rd_data_o, output rd_ready_i);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through circular buffer with overwrite or drop on full.
module trace_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  parameter int WRAP = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [AW:0]      fill_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] fill_q, fill_d;
  logic full, pop, wr, adv_rd;
  assign valid_o = fill_q != '0;
  assign fill_o = fill_q;
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  always_comb begin
    full = fill_q == (AW+1)'(DEPTH);
    pop = pop_i & valid_o & ~clr_i;
    wr = push_i & ~clr_i & (~full | pop | (WRAP != 0));
    ovf_o = push_i & ~clr_i & full & ~pop;
    adv_rd = pop | (wr & full & ~pop);
    wr_d = clr_i ? '0 : wr_q + AW'(wr);
    rd_d = clr_i ? '0 : rd_q + AW'(adv_rd);
    fill_d = clr_i ? '0 : fill_q + (AW+1)'(wr & ~pop & ~full) - (AW+1)'(pop & ~wr);
  end
  always_ff @(posedge clk_i) if (wr) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: cycle/stall/flush counters, cycle-budget halt and trace capture.
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int STOP_CYCLE = 18,
  parameter int WRAP = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o,
  output logic                   halt_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   overflow_o,
  cpu_trace_monitor_if.slave     rd
);
  localparam int EW = entry_w(PC_W);
  localparam int SB = stall_bit(PC_W);
  localparam int FB = flush_bit(PC_W);
  logic [CNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d;
  logic halt_q, halt_d, ovf_q, ovf_d, capture, fifo_ovf;
  logic [EW-1:0] entry;
  always_comb begin
    capture = start_i & ~halt_q & ~clear_i;
    entry = '0;
    entry[PC_LSB +: PC_W] = pc_i;
    entry[SB] = stall_i;
    entry[FB] = flush_i;
    cyc_d = clear_i ? '0 : capture ? CNT_W'(sat_inc(64'(cyc_q), CNT_W)) : cyc_q;
    stl_d = clear_i ? '0 : (capture & stall_i) ? CNT_W'(sat_inc(64'(stl_q), CNT_W)) : stl_q;
    fls_d = clear_i ? '0 : (capture & flush_i) ? CNT_W'(sat_inc(64'(fls_q), CNT_W)) : fls_q;
    halt_d = ~clear_i & (halt_q | ((STOP_CYCLE != 0) & capture & (cyc_d == CNT_W'(STOP_CYCLE))));
    ovf_d = ~clear_i & (ovf_q | fifo_ovf);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
      halt_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
      fls_q <= fls_d;
      halt_q <= halt_d;
      ovf_q <= ovf_d;
    end
  end
  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .WRAP(WRAP)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clear_i),
    .push_i(capture),
    .pop_i(rd.rd_ready_i),
    .data_i(entry),
    .data_o(rd.rd_data_o),
    .valid_o(rd.rd_valid_o),
    .fill_o(fill_o),
    .ovf_o(fifo_ovf)
  );
  assign cycle_cnt_o = cyc_q;
  assign stall_cnt_o = stl_q;
  assign flush_cnt_o = fls_q;
  assign halt_o = halt_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed checks of halt, wrap/drop, drain, clear and async reset.
module tb_cpu_trace_monitor;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start = 1'b0, clear = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] pc = '0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  cpu_trace_monitor_if #(.W(34)) ifa(), ifb(), ifc(), ifd();
  logic [31:0] cyc_a, stl_a, fls_a, cyc_b, stl_b, fls_b, cyc_c, stl_c, fls_c;
  logic [2:0] cyc_d, stl_d, fls_d, fill_d;
  logic [4:0] fill_a, fill_b, fill_c;
  logic halt_a, halt_b, halt_c, halt_d, ovf_a, ovf_b, ovf_c, ovf_d;
  cpu_trace_monitor u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .clear_i(clear), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .cycle_cnt_o(cyc_a), .stall_cnt_o(stl_a), .flush_cnt_o(fls_a), .halt_o(halt_a), .fill_o(fill_a),
    .overflow_o(ovf_a), .rd(ifa)
  );
  cpu_trace_monitor #(.STOP_CYCLE(0)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .cycle_cnt_o(cyc_b), .stall_cnt_o(stl_b), .flush_cnt_o(fls_b), .halt_o(halt_b), .fill_o(fill_b),
    .overflow_o(ovf_b), .rd(ifb)
  );
  cpu_trace_monitor #(.STOP_CYCLE(0), .WRAP(0)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .cycle_cnt_o(cyc_c), .stall_cnt_o(stl_c), .flush_cnt_o(fls_c), .halt_o(halt_c), .fill_o(fill_c),
    .overflow_o(ovf_c), .rd(ifc)
  );
  cpu_trace_monitor #(.STOP_CYCLE(0), .CNT_W(3), .DEPTH(4)) u_d (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .cycle_cnt_o(cyc_d), .stall_cnt_o(stl_d), .flush_cnt_o(fls_d), .halt_o(halt_d), .fill_o(fill_d),
    .overflow_o(ovf_d), .rd(ifd)
  );
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [33:0] ent(logic f, logic s, int p);
    return {f, s, p[31:0]};
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    ifa.rd_ready_i = 1'b0;
    ifb.rd_ready_i = 1'b0;
    ifc.rd_ready_i = 1'b0;
    ifd.rd_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cyc", 64'(cyc_a), 64'(0));
    chk("rst_fill", 64'(fill_a), 64'(0));
    chk("rst_halt", 64'(halt_a), 64'(0));
    chk("rst_ovf", 64'(ovf_a), 64'(0));
    chk("rst_valid", 64'(ifa.rd_valid_o), 64'(0));
    chk("rst_data", 64'(ifa.rd_data_o), 64'(0));
    rst = 1'b0;
    start_a = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'(4 * i);
      stall = (i == 2 || i == 3);
      flush = (i == 4);
      step();
      if (i == 16) chk("halt_before", 64'(halt_a), 64'(0));
      if (i == 17) begin
        chk("halt_cyc", 64'(cyc_a), 64'(18));
        chk("halt_rise", 64'(halt_a), 64'(1));
      end
    end
    stall = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    repeat (3) step();
    chk("frz_cyc", 64'(cyc_a), 64'(18));
    chk("frz_fill", 64'(fill_a), 64'(16));
    chk("frz_halt", 64'(halt_a), 64'(1));
    chk("a_stall", 64'(stl_a), 64'(2));
    chk("b_cyc", 64'(cyc_b), 64'(20));
    chk("b_stall", 64'(stl_b), 64'(2));
    chk("b_flush", 64'(fls_b), 64'(1));
    chk("b_fill", 64'(fill_b), 64'(16));
    chk("b_ovf", 64'(ovf_b), 64'(1));
    chk("b_halt", 64'(halt_b), 64'(0));
    chk("c_cyc", 64'(cyc_c), 64'(20));
    chk("c_fill", 64'(fill_c), 64'(16));
    chk("c_ovf", 64'(ovf_c), 64'(1));
    chk("d_sat_cyc", 64'(cyc_d), 64'(7));
    chk("d_stall", 64'(stl_d), 64'(2));
    chk("d_fill", 64'(fill_d), 64'(4));
    ifb.rd_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_b", 64'(ifb.rd_data_o), 64'(ent(k == 0, 1'b0, 16 + 4 * k)));
      step();
    end
    chk("b_empty_valid", 64'(ifb.rd_valid_o), 64'(0));
    chk("b_empty_fill", 64'(fill_b), 64'(0));
    ifb.rd_ready_i = 1'b0;
    ifc.rd_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_c", 64'(ifc.rd_data_o), 64'(ent(k == 4, k == 2 || k == 3, 4 * k)));
      step();
    end
    chk("c_empty_valid", 64'(ifc.rd_valid_o), 64'(0));
    ifc.rd_ready_i = 1'b0;
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_b_cyc", 64'(cyc_b), 64'(0));
    chk("clr_b_ovf", 64'(ovf_b), 64'(0));
    chk("clr_a_halt", 64'(halt_a), 64'(0));
    chk("clr_a_cyc", 64'(cyc_a), 64'(0));
    for (int i = 0; i < 16; i++) begin
      pc = 32'(256 + 4 * i);
      step();
    end
    chk("refill_fill", 64'(fill_b), 64'(16));
    chk("refill_ovf", 64'(ovf_b), 64'(0));
    ifb.rd_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc = 32'(320 + 4 * k);
      chk("fullrw_data", 64'(ifb.rd_data_o), 64'(ent(1'b0, 1'b0, 256 + 4 * k)));
      step();
      chk("fullrw_fill", 64'(fill_b), 64'(16));
    end
    chk("fullrw_ovf", 64'(ovf_b), 64'(0));
    chk("fullrw_head", 64'(ifb.rd_data_o), 64'(ent(1'b0, 1'b0, 288)));
    chk("fullrw_cyc", 64'(cyc_b), 64'(24));
    chk("a_rehalt_cyc", 64'(cyc_a), 64'(18));
    chk("a_rehalt", 64'(halt_a), 64'(1));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr2_fill", 64'(fill_b), 64'(0));
    chk("clr2_cyc", 64'(cyc_b), 64'(0));
    chk("clr2_valid", 64'(ifb.rd_valid_o), 64'(0));
    chk("clr2_data", 64'(ifb.rd_data_o), 64'(0));
    chk("clr2_a_halt", 64'(halt_a), 64'(0));
    ifb.rd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(1280 + 4 * i);
      step();
    end
    chk("post_cyc", 64'(cyc_b), 64'(3));
    chk("post_fill", 64'(fill_b), 64'(3));
    chk("post_head", 64'(ifb.rd_data_o), 64'(ent(1'b0, 1'b0, 1280)));
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", 64'(cyc_b), 64'(0));
    chk("arst_fill", 64'(fill_b), 64'(0));
    chk("arst_valid", 64'(ifb.rd_valid_o), 64'(0));
    chk("arst_data", 64'(ifb.rd_data_o), 64'(0));
    chk("arst_a_cyc", 64'(cyc_a), 64'(0));
    #1 rst = 1'b0;
    start = 1'b0;
    start_a = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu_trace_monitor.md
Name: cpu_trace_monitor

Overview:
Synthesisable cycle monitor for the CPU cores. It counts cycles, stall cycles and flush events, and captures a per-cycle trace of {flush, stall, PC} into a circular buffer. It raises a halt request after a programmable cycle budget. It sits beside the CPU top and takes PC, stall and flush taps. Trace entries drain through a valid/ready read port to a debug host or the bench.

Parameters:
PC_W, 32, PC tap width
DEPTH, 16, trace entries; power of 2, >=2
CNT_W, 32, counter width
STOP_CYCLE, 18, capture count that asserts halt; 0 = never halt
WRAP, 1, 1: overwrite oldest entry when full; 0: drop new entries when full

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  enables capture/counting
clear_i  in  1  synchronous clear of counters, buffer, halt, overflow
pc_i  in  PC_W  current PC
stall_i  in  1  pipeline stall this cycle
flush_i  in  1  pipeline flush this cycle
cycle_cnt_o  out  CNT_W  captured cycles
stall_cnt_o  out  CNT_W  captured cycles with stall_i=1
flush_cnt_o  out  CNT_W  captured cycles with flush_i=1
halt_o  out  1  cycle budget reached
fill_o  out  $clog2(DEPTH)+1  entries held
overflow_o  out  1  sticky: an entry was overwritten or dropped
rd_valid_o  out  1  buffer non-empty
rd_ready_i  in  1  host accepts rd_data_o
rd_data_o  out  PC_W+2  {flush, stall, pc} of oldest entry

Behaviour:
- Reset (async, rst_i=1): all counters 0, fill_o 0, pointers 0, halt_o 0, overflow_o 0, rd_valid_o 0, rd_data_o 0. Outputs go to these values immediately, including mid-run.
- capture = start_i & ~halt_o & ~clear_i, sampled at the rising edge.
- On capture:
  - cycle_cnt_o +1.
  - stall_cnt_o +1 if stall_i=1.
  - flush_cnt_o +1 if flush_i=1.
  - All counters saturate at 2^CNT_W-1.
  - One entry is written.
- Halt: if STOP_CYCLE!=0, halt_o rises on the same edge that cycle_cnt_o becomes STOP_CYCLE. halt_o is sticky until clear_i or reset. While halted, counters and the buffer are frozen, but readout continues.
- Buffer: first-word-fall-through. rd_data_o = entry at rd_ptr, from registered storage with combinational select. rd_valid_o = (fill_o!=0).
- Pop: occurs when rd_valid_o & rd_ready_i. rd_ptr advances modulo DEPTH. rd_ready_i while empty is ignored.
- Not full: a write alone gives fill +1; a pop alone gives fill -1; a write and pop together leave fill unchanged.
- Full, write, no pop:
  - WRAP=1: the new entry overwrites the oldest, and rd_ptr and wr_ptr both advance. fill stays DEPTH. overflow_o is set.
  - WRAP=0: the entry is dropped and the pointers hold. overflow_o is set. Counters still increment.
- Full, write and pop together: normal pop plus write, fill stays DEPTH, overflow_o is not set.
- Pointers wrap modulo DEPTH. fill_o reaches DEPTH exactly; pointer equality is disambiguated by fill.
- clear_i: on the edge, everything returns to reset values. clear_i beats a concurrent capture and a concurrent pop, so neither has an effect that cycle.
- start_i low: no capture. Readout is unaffected.

Decomposition:
- Shared package trace_pkg:
  - entry field offsets: PC LSB 0, STALL_BIT = PC_W, FLUSH_BIT = PC_W+1
  - entry width function
  - saturating-increment function
- Sub-module trace_fifo: circular buffer with parameters WIDTH, DEPTH and WRAP. Ports: push, pop, data, fill, overflow pulse.
- Top: counters, halt logic, capture gating, clear.

Test Plan:
- Defaults, start_i=1, pc_i=0,4,8..., no stall/flush: after 18 edges cycle_cnt_o=18 and halt_o=1. Over 5 more edges cycle_cnt_o stays 18 and fill_o stays 16.
- stall_i=1 on captures 3-4, flush_i=1 on capture 5, STOP_CYCLE=0: stall_cnt_o=2, flush_cnt_o=1. Read entries 3/4 show stall bit set; entry 5 shows flush bit set.
- WRAP=1, DEPTH=16, STOP_CYCLE=0, 20 captures, no reads: fill_o=16, overflow_o=1, first rd_data_o pc=16. Draining 16 entries yields pc=16..76, then rd_valid_o=0.
- WRAP=0, same stimulus: fill_o=16, overflow_o=1, first pc=0, last pc=60, cycle_cnt_o=20.
- Buffer full, rd_ready_i=1 with a capture each cycle for 8 cycles: fill_o stays 16, overflow_o stays 0, data pops in order.
- Reset pulsed mid-run between edges: all outputs 0 before the next edge. clear_i=1 with rd_ready_i=1 and capture in the same cycle: everything 0 next edge, no pop or write observed.
